// File: rtl/alu_pkg.sv
// Shared opcode, flag and enable definitions for the pipelined ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_GT  = 4'd2,
    OP_LE  = 4'd3,
    OP_LTU = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_SRA = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  // Opcodes 11..15 have no defined operation
  localparam logic [15:0] OP_RESERVED_MASK = 16'hF800;

  function automatic logic opEnabled(input logic [3:0] op, input logic [15:0] opsEn);
    logic [15:0] reserved;
    reserved = OP_RESERVED_MASK;
    return opsEn[op] && !reserved[op];
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational datapath: maps {a, b, op} to {result, flags, err}.
module alu_core #(
  parameter int          WIDTH  = 16,
  parameter logic [15:0] OPS_EN = 16'h07FF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags,
  output logic             o_err
);
  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  logic             w_isSub;
  logic             w_isArith;
  logic             w_enabled;
  logic [WIDTH-1:0] w_bOp;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [SHW:0]     w_amtRaw;
  logic [SHW:0]     w_shAmt;
  logic [WIDTH-1:0] w_raw;
  alu_flags_t       w_flags;

  // One shared adder: SUB inverts B and injects the +1 as carry-in
  assign w_isSub   = (i_op == OP_SUB);
  assign w_isArith = (i_op == OP_ADD) || w_isSub;
  assign w_enabled = opEnabled(i_op, OPS_EN);
  assign w_bOp     = w_isSub ? ~i_b : i_b;
  assign w_sum     = {1'b0, i_a} + {1'b0, w_bOp} + {{WIDTH{1'b0}}, w_isSub};
  assign w_ovf     = (i_a[WIDTH-1] == w_bOp[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

  // Shift amount folded modulo WIDTH so non-power-of-two widths stay in range
  assign w_amtRaw = {1'b0, i_b[SHW-1:0]};
  assign w_shAmt  = (w_amtRaw >= (SHW+1)'(WIDTH)) ? (w_amtRaw - (SHW+1)'(WIDTH)) : w_amtRaw;

  always_comb begin
    w_raw = '0;
    case (alu_op_e'(i_op))
      OP_ADD:  w_raw = w_sum[WIDTH-1:0];
      OP_SUB:  w_raw = w_sum[WIDTH-1:0];
      OP_GT:   w_raw = {{(WIDTH-1){1'b0}}, ($signed(i_a) > $signed(i_b))};
      OP_LE:   w_raw = {{(WIDTH-1){1'b0}}, ($signed(i_a) <= $signed(i_b))};
      OP_LTU:  w_raw = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      OP_AND:  w_raw = i_a & i_b;
      OP_OR:   w_raw = i_a | i_b;
      OP_XOR:  w_raw = i_a ^ i_b;
      OP_SHL:  w_raw = i_a << w_shAmt;
      OP_SHR:  w_raw = i_a >> w_shAmt;
      OP_SRA:  w_raw = $signed(i_a) >>> w_shAmt;
      default: w_raw = '0;
    endcase
  end

  // Disabled or reserved opcodes squash result and flags and raise err
  always_comb begin
    w_flags  = '0;
    o_result = '0;
    o_err    = 1'b1;
    if (w_enabled) begin
      o_result  = w_raw;
      o_err     = 1'b0;
      w_flags.n = w_raw[WIDTH-1];
      w_flags.z = (w_raw == '0);
      w_flags.c = w_isArith & w_sum[WIDTH];
      w_flags.v = w_isArith & w_ovf;
    end
  end

  assign o_flags = w_flags;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds results.
module alu_pipe #(
  parameter int          WIDTH  = 16,
  parameter int          TAG_W  = 4,
  parameter logic [15:0] OPS_EN = 16'h07FF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);
  import alu_pkg::*;

  logic             r_s1Valid;
  logic [WIDTH-1:0] r_s1A;
  logic [WIDTH-1:0] r_s1B;
  logic [3:0]       r_s1Op;
  logic [TAG_W-1:0] r_s1Tag;

  logic             r_s2Valid;
  logic [WIDTH-1:0] r_s2Result;
  logic [3:0]       r_s2Flags;
  logic             r_s2Err;
  logic [TAG_W-1:0] r_s2Tag;

  logic             w_s1Load;
  logic             w_s2Load;
  logic [WIDTH-1:0] w_coreResult;
  logic [3:0]       w_coreFlags;
  logic             w_coreErr;

  // Ready chains combinationally from the consumer back to the source
  assign w_s2Load = !r_s2Valid || out_ready;
  assign w_s1Load = !r_s1Valid || w_s2Load;
  assign in_ready = w_s1Load && !rst;

  alu_core #(
    .WIDTH  (WIDTH),
    .OPS_EN (OPS_EN)
  ) u_core (
    .i_a      (r_s1A),
    .i_b      (r_s1B),
    .i_op     (r_s1Op),
    .o_result (w_coreResult),
    .o_flags  (w_coreFlags),
    .o_err    (w_coreErr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid  <= 1'b0;
      r_s1A      <= '0;
      r_s1B      <= '0;
      r_s1Op     <= '0;
      r_s1Tag    <= '0;
      r_s2Valid  <= 1'b0;
      r_s2Result <= '0;
      r_s2Flags  <= '0;
      r_s2Err    <= 1'b0;
      r_s2Tag    <= '0;
    end else begin
      if (w_s1Load) begin
        r_s1Valid <= in_valid;
        if (in_valid) begin
          r_s1A   <= in_a;
          r_s1B   <= in_b;
          r_s1Op  <= in_op;
          r_s1Tag <= in_tag;
        end
      end
      // Data only moves with a real beat so idle outputs stay quiet
      if (w_s2Load) begin
        r_s2Valid <= r_s1Valid;
        if (r_s1Valid) begin
          r_s2Result <= w_coreResult;
          r_s2Flags  <= w_coreFlags;
          r_s2Err    <= w_coreErr;
          r_s2Tag    <= r_s1Tag;
        end
      end
    end
  end

  assign out_valid  = r_s2Valid;
  assign out_result = r_s2Result;
  assign out_flags  = r_s2Flags;
  assign out_err    = r_s2Err;
  assign out_tag    = r_s2Tag;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe with a second, op-limited instance.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_op;
  logic [3:0]  in_tag;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic        out_err;
  logic [3:0]  out_tag;

  logic        limInReady;
  logic        limOutValid;
  logic [15:0] limOutResult;
  logic [3:0]  limOutFlags;
  logic        limOutErr;
  logic [3:0]  limOutTag;

  int checks   = 0;
  int failures = 0;

  alu_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_err    (out_err),
    .out_tag    (out_tag)
  );

  alu_pipe #(.WIDTH(16), .TAG_W(4), .OPS_EN(16'h0003)) dutLim (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (limInReady),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .out_valid  (limOutValid),
    .out_ready  (out_ready),
    .out_result (limOutResult),
    .out_flags  (limOutFlags),
    .out_err    (limOutErr),
    .out_tag    (limOutTag)
  );

  always #5 clk = ~clk;

  // Advance one cycle and land just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [3:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  // Single beat through an empty pipe; result is checked two edges after acceptance
  task automatic runOp(input string name, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] tag, input logic [15:0] expRes,
                       input logic [3:0] expFlags, input logic expErr);
    out_ready = 1'b1;
    applyStimulus(op, a, b, tag);
    checkOutput({name, "_inReady"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    checkOutput({name, "_notYet"}, 32'(out_valid), 32'd0);
    step();
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_result"}, 32'(out_result), 32'(expRes));
    checkOutput({name, "_flags"}, 32'(out_flags), 32'(expFlags));
    checkOutput({name, "_err"}, 32'(out_err), 32'(expErr));
    checkOutput({name, "_tag"}, 32'(out_tag), 32'(tag));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_tag    = '0;

    // Reset state
    step();
    step();
    checkOutput("rst_outValid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", 32'(out_result), 32'd0);
    checkOutput("rst_flags", 32'(out_flags), 32'd0);
    checkOutput("rst_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_inReadyAfter", 32'(in_ready), 32'd1);

    // Arithmetic, compare, logic, shift and error vectors
    runOp("addOvf", 4'd0, 16'h7FFF, 16'h0001, 4'h5, 16'h8000, 4'b1001, 1'b0);
    runOp("addCarry", 4'd0, 16'hFFFF, 16'h0001, 4'h6, 16'h0000, 4'b0110, 1'b0);
    runOp("subZero", 4'd1, 16'h0005, 16'h0005, 4'h7, 16'h0000, 4'b0110, 1'b0);
    runOp("subBorrow", 4'd1, 16'h0003, 16'h0005, 4'h8, 16'hFFFE, 4'b1000, 1'b0);
    runOp("gtSigned", 4'd2, 16'h8000, 16'h0001, 4'h9, 16'h0000, 4'b0100, 1'b0);
    runOp("leSigned", 4'd3, 16'h8000, 16'h0001, 4'hA, 16'h0001, 4'b0000, 1'b0);
    runOp("ltu", 4'd4, 16'h0001, 16'h8000, 4'hB, 16'h0001, 4'b0000, 1'b0);
    runOp("or", 4'd6, 16'h1200, 16'h0034, 4'hC, 16'h1234, 4'b0000, 1'b0);
    runOp("xorZero", 4'd7, 16'hFFFF, 16'hFFFF, 4'hD, 16'h0000, 4'b0100, 1'b0);
    runOp("shl", 4'd8, 16'h0001, 16'h0011, 4'hE, 16'h0002, 4'b0000, 1'b0);
    runOp("shr", 4'd9, 16'h8000, 16'h000F, 4'hF, 16'h0001, 4'b0000, 1'b0);
    runOp("sra", 4'd10, 16'h8000, 16'h0013, 4'h1, 16'hF000, 4'b1000, 1'b0);
    runOp("reserved", 4'hC, 16'h1234, 16'h5678, 4'h2, 16'h0000, 4'b0000, 1'b1);
    runOp("andEnabled", 4'd5, 16'h00F0, 16'h0FF0, 4'h3, 16'h00F0, 4'b0000, 1'b0);
    checkOutput("andLim_err", 32'(limOutErr), 32'd1);
    checkOutput("andLim_result", 32'(limOutResult), 32'd0);
    checkOutput("andLim_flags", 32'(limOutFlags), 32'd0);

    // Backpressure: two accepts fill the pipe, then in_ready drops
    step();
    out_ready = 1'b0;
    applyStimulus(4'd0, 16'h0001, 16'h0000, 4'h1);
    checkOutput("bp_rdy1", 32'(in_ready), 32'd1);
    step();
    applyStimulus(4'd0, 16'h0002, 16'h0000, 4'h2);
    checkOutput("bp_rdy2", 32'(in_ready), 32'd1);
    step();
    applyStimulus(4'd0, 16'h0003, 16'h0000, 4'h3);
    checkOutput("bp_rdyFull", 32'(in_ready), 32'd0);
    checkOutput("bp_holdTag", 32'(out_tag), 32'd1);
    step();
    in_a = 16'hDEAD;
    checkOutput("bp_holdValid", 32'(out_valid), 32'd1);
    checkOutput("bp_holdTag2", 32'(out_tag), 32'd1);
    checkOutput("bp_holdResult", 32'(out_result), 32'd1);
    checkOutput("bp_rdyStill", 32'(in_ready), 32'd0);
    step();
    in_a = 16'h0003;
    checkOutput("bp_holdTag3", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_drainFill", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    checkOutput("bp_tag2", 32'(out_tag), 32'd2);
    checkOutput("bp_res2", 32'(out_result), 32'd2);
    step();
    checkOutput("bp_tag3", 32'(out_tag), 32'd3);
    checkOutput("bp_res3", 32'(out_result), 32'd3);
    step();
    checkOutput("bp_empty", 32'(out_valid), 32'd0);

    // Full-rate stream: one result per cycle
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'd0, 16'(i * 16), 16'h0001, 4'(4 + i));
      checkOutput("fr_inReady", 32'(in_ready), 32'd1);
      step();
      if (i >= 1) begin
        checkOutput("fr_valid", 32'(out_valid), 32'd1);
        checkOutput("fr_tag", 32'(out_tag), 32'(4 + i - 1));
        checkOutput("fr_result", 32'(out_result), 32'((i - 1) * 16 + 1));
      end
    end
    in_valid = 1'b0;
    step();
    checkOutput("fr_lastTag", 32'(out_tag), 32'd9);
    checkOutput("fr_lastResult", 32'(out_result), 32'd81);
    step();
    checkOutput("fr_empty", 32'(out_valid), 32'd0);

    // Reset with both stages full discards everything in flight
    out_ready = 1'b0;
    applyStimulus(4'd7, 16'h00FF, 16'h0F0F, 4'hA);
    step();
    applyStimulus(4'd7, 16'h00FF, 16'h0F0F, 4'hB);
    step();
    checkOutput("mr_fullValid", 32'(out_valid), 32'd1);
    applyStimulus(4'd0, 16'h1111, 16'h2222, 4'hC);
    rst = 1'b1;
    step();
    checkOutput("mr_outValid", 32'(out_valid), 32'd0);
    checkOutput("mr_result", 32'(out_result), 32'd0);
    checkOutput("mr_flags", 32'(out_flags), 32'd0);
    checkOutput("mr_err", 32'(out_err), 32'd0);
    checkOutput("mr_tag", 32'(out_tag), 32'd0);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("mr_inReady", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("mr_noStale", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the team's 16-bit combinational add/sub/compare ALU. Operand width and the enabled-operation mask are generic. It adds logic and shift operations, NZCV-style flags, a reserved-opcode error, and a two-stage valid/ready pipeline with full backpressure. It sits between an operand-issue source and a result consumer, and carries a caller tag through with each result.

## Interface
- `WIDTH`, 16: operand/result width in bits; ≥ 2.
- `TAG_W`, 4: width of the pass-through tag; ≥ 1.
- `OPS_EN`, 16'h07FF: bit n set enables opcode n. Disabled or reserved opcodes report an error.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B; shift amount is `in_b[$clog2(WIDTH)-1:0]`.
- `in_op`  in  4  opcode, `alu_pkg::alu_op_e`.
- `in_tag`  in  TAG_W  opaque tag, returned unchanged.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  WIDTH  result.
- `out_flags`  out  4  {N, Z, C, V}.
- `out_err`  out  1  opcode was reserved or disabled.
- `out_tag`  out  TAG_W  tag of this result.

## Operation
- Opcodes, 4-bit binary:
  - 0 ADD, 1 SUB.
  - 2 GT (signed A>B), 3 LE (signed A≤B), 4 LTU (unsigned A<B).
  - 5 AND, 6 OR, 7 XOR.
  - 8 SHL, 9 SHR (logical), 10 SRA (arithmetic).
  - 11–15 reserved.
- Add/sub datapath:
  - Single WIDTH+1-bit adder: A + (SUB ? ~B : B) + SUB.
  - Result is the low WIDTH bits; the sum wraps modulo 2^WIDTH.
- Compares return a zero-extended 1 or 0.
- Shifts:
  - Shift amount is taken modulo WIDTH; upper bits of B are ignored.
  - SRA replicates A[WIDTH-1].
- Flags:
  - N = result[WIDTH-1]; Z = (result == 0). N and Z are valid for every opcode.
  - C = adder carry-out for ADD and SUB. For SUB, C=1 means no borrow.
  - V = signed overflow for ADD and SUB.
  - C and V are 0 for all other opcodes.
- Error case: a reserved opcode, or an opcode whose `OPS_EN` bit is 0, gives result 0, flags 0 and `out_err`=1. The beat is still delivered in order.
- Pipeline:
  - Stage S1 registers operands, opcode and tag.
  - Stage S2 registers result, flags, err and tag. S2 drives the `out_*` ports directly.
  - Each stage has its own valid bit.
- Flow control:
  - S2 loads when `!out_valid || out_ready`.
  - S1 loads when `!s1_valid || s2_load`.
  - `in_ready = !s1_valid || s2_load`. This is a combinational ready chain; there is no skid buffer.
- Ordering: strictly in order; no beat is dropped or duplicated.

## Timing
- Latency:
  - A beat accepted at edge t (`in_valid && in_ready`) appears on `out_*` after edge t+1.
  - This is 2 cycles minimum.
  - Throughput is 1 beat/cycle while `out_ready` stays high.
- Hold rule: while `out_valid && !out_ready`, all `out_*` signals hold stable.
  - S1 holds if it is full.
  - `in_ready` falls once both stages are full.
- Drain and fill in the same cycle: when `out_ready` is high and the pipe is full, a new beat is accepted that cycle.
- Reset:
  - While `rst`=1: S1 and S2 valid bits clear; `out_valid`=0; `out_result`, `out_flags`, `out_err` and `out_tag` are 0.
  - `in_ready`=1 in the first cycle after `rst` deasserts.
  - Reset mid-operation discards all in-flight beats.
  - A beat offered during reset is not accepted.
- `in_*` signals are sampled only on an accepting edge. Changes to `in_*` while `in_ready`=0 have no effect.

## Structure
- `alu_pkg` holds:
  - `alu_op_e` (4-bit opcode enum with the values above).
  - `alu_flags_t` packed struct {n, z, c, v}.
  - `OP_RESERVED_MASK`, the constant covering opcodes 11–15.
- One sub-module, `alu_core`: a purely combinational datapath (WIDTH, OPS_EN) mapping {a, b, op} to {result, flags, err}.
  - It is instantiated between S1 and S2.
  - `alu_pipe` owns only the registers and handshake.

## Test plan
All scenarios use WIDTH=16 and TAG_W=4.
- ADD overflow: A=0x7FFF, B=0x0001 → result 0x8000; N=1, Z=0, C=0, V=1; tag echoed 2 cycles after acceptance.
- SUB zero: A=0x0005, B=0x0005 → result 0x0000; Z=1, C=1, V=0.
- Signed vs unsigned compare:
  - GT with A=0x8000, B=0x0001 → 0x0000.
  - LE with the same operands → 0x0001.
  - LTU with A=0x0001, B=0x8000 → 0x0001.
- Shifts and error:
  - SRA with A=0x8000, B=0x0013 (amount 3) → 0xF000.
  - Opcode 0xC → result 0, flags 0, `out_err`=1.
  - With `OPS_EN`=16'h0003, opcode 5 → `out_err`=1.
- Backpressure:
  - Hold `out_ready`=0 and stream tags 1, 2, 3 → `in_ready` drops after two accepts; `out_*` holds tag 1 stable.
  - Release → tags 1, 2, 3 emerge in order, once each.
  - Full-rate stream with `out_ready`=1 → 1 result/cycle.
- Reset mid-stream: assert `rst` with both stages valid → `out_valid`=0 and outputs 0 on the next cycle; `in_ready`=1 after release; no stale beat ever emerges.
